// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int UART_DATA_W            = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: purely combinational, zero latency, no backpressure.
// Scans requesters starting at i_rr_ptr and wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_any_req
);

  logic [PTR_W:0] w_idx;

  // Scan from the far end back toward the pointer so the closest requester wins last.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (i_req[w_idx[PTR_W-1:0]]) begin
        o_winner  = w_idx[PTR_W-1:0];
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART Transmitter: grant + tx_start one cycle after req_valid, one frame per grant.
// Requesters hold until their req_ready pulse; watchdog abort under UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = UART_DATA_W,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int PTR_W          = $clog2(NUM_REQ)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_tx_in,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic [PTR_W-1:0]          o_grant_id,
  output logic [CNT_W-1:0]          o_frame_count,
  output logic                      o_timeout_err
);

  state_t               r_state, w_nxt_state;
  logic [PTR_W-1:0]     r_rr_ptr, w_nxt_rr_ptr;
  logic [PTR_W-1:0]     r_grant_id, w_nxt_grant_id;
  logic [DATA_W-1:0]    r_tx_in, w_nxt_tx_in;
  logic [NUM_REQ-1:0]   r_req_ready, w_nxt_req_ready;
  logic                 r_tx_start, w_nxt_tx_start;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_frame_count, w_nxt_frame_count;
  logic                 r_timeout_err, w_nxt_timeout_err;
  logic [PTR_W-1:0]     w_winner;
  logic                 w_any_req;
  logic [PTR_W-1:0]     w_ptr_after_grant;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [31:0]          r_wdog, w_nxt_wdog;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic                 w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req     (i_req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_ptr_after_grant = (r_grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant_id + PTR_W'(1);

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_rr_ptr      = r_rr_ptr;
    w_nxt_grant_id    = r_grant_id;
    w_nxt_tx_in       = r_tx_in;
    w_nxt_req_ready   = '0;
    w_nxt_tx_start    = r_tx_start;
    w_nxt_frame_count = r_frame_count;
    w_nxt_timeout_err = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    w_nxt_wdog        = r_wdog;
`endif
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_nxt_tx_in     = i_req_data[w_winner*DATA_W +: DATA_W];
          w_nxt_grant_id  = w_winner;
          w_nxt_req_ready = NUM_REQ'(1) << w_winner;
          w_nxt_tx_start  = 1'b1;
          w_nxt_state     = SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          w_nxt_wdog      = '0;
`endif
        end
      end
      SEND: begin
        if (i_tx_done) begin
          w_nxt_tx_start    = 1'b0;
          w_nxt_frame_count = r_frame_count + CNT_W'(1);
          w_nxt_state       = RELEASE;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
          w_nxt_tx_start    = 1'b0;
          w_nxt_timeout_err = 1'b1;
          w_nxt_state       = RELEASE;
        end else begin
          w_nxt_wdog        = r_wdog + 32'd1;
        end
`endif
      end
      RELEASE: begin
        // A held-level tx_done must fall before the next grant can start a frame.
        if (!i_tx_done) begin
          w_nxt_rr_ptr = w_ptr_after_grant;
          w_nxt_state  = IDLE;
        end
      end
      default: begin
        w_nxt_tx_start = 1'b0;
        w_nxt_state    = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_tx_in       <= '0;
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_timeout_err <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_state       <= w_nxt_state;
      r_rr_ptr      <= w_nxt_rr_ptr;
      r_grant_id    <= w_nxt_grant_id;
      r_tx_in       <= w_nxt_tx_in;
      r_req_ready   <= w_nxt_req_ready;
      r_tx_start    <= w_nxt_tx_start;
      r_busy        <= (w_nxt_state != IDLE);
      r_frame_count <= w_nxt_frame_count;
      r_timeout_err <= w_nxt_timeout_err;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      r_wdog        <= w_nxt_wdog;
`endif
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_tx_in       = r_tx_in;
  assign o_tx_start    = r_tx_start;
  assign o_busy        = r_busy;
  assign o_grant_id    = r_grant_id;
  assign o_frame_count = r_frame_count;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small Transmitter tx_done model.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  o_req_ready;
  logic [7:0]  o_tx_in;
  logic        o_tx_start;
  logic        tx_done;
  logic        o_busy;
  logic [1:0]  o_grant_id;
  logic [15:0] o_frame_count;
  logic        o_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_mode = 0;  // 0: drive tx_done, 2: never drive tx_done
  int done_len  = 1;  // cycles tx_done is held high

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (o_req_ready),
    .o_tx_in       (o_tx_in),
    .o_tx_start    (o_tx_start),
    .i_tx_done     (tx_done),
    .o_busy        (o_busy),
    .o_grant_id    (o_grant_id),
    .o_frame_count (o_frame_count),
    .o_timeout_err (o_timeout_err)
  );

  // Transmitter stand-in: tx_done rises 10 cycles after tx_start rises.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && done_mode != 2) begin
        repeat (9) @(negedge clk);
        tx_done = 1'b1;
        repeat (done_len) @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic await_grant(input string tag, input logic [1:0] exp_id, input logic [7:0] exp_dat);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (o_req_ready != 4'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_id"}, 32'(o_grant_id), 32'(exp_id));
    check_eq({tag, "_dat"}, 32'(o_tx_in), 32'(exp_dat));
    check_eq({tag, "_rdy"}, 32'(o_req_ready), 32'(4'b0001 << exp_id));
    check_eq({tag, "_start"}, 32'(o_tx_start), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!o_busy) break;
    end
    check_eq({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0;
    req_data  = 32'h0;
    tick();
    tick();
    check_eq("rst_start", 32'(o_tx_start), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_cnt", 32'(o_frame_count), 32'd0);
    check_eq("rst_id", 32'(o_grant_id), 32'd0);
    check_eq("rst_txin", 32'(o_tx_in), 32'd0);
    check_eq("rst_rdy", 32'(o_req_ready), 32'd0);
    check_eq("rst_err", 32'(o_timeout_err), 32'd0);
    reset = 1'b0;

    // Single request, pulsed tx_done
    req_data[7:0] = 8'h75;
    req_valid     = 4'b0001;
    await_grant("single", 2'd0, 8'h75);
    req_valid = 4'b0;
    tick();
    check_eq("single_rdy_pulse", 32'(o_req_ready), 32'd0);
    check_eq("single_busy", 32'(o_busy), 32'd1);
    wait_done("single");
    check_eq("single_start_drop", 32'(o_tx_start), 32'd0);
    check_eq("single_cnt", 32'(o_frame_count), 32'd1);
    check_eq("single_release_busy", 32'(o_busy), 32'd1);
    tick();
    check_eq("single_busy_low", 32'(o_busy), 32'd0);

    // All four requesting from a fresh pointer
    do_reset();
    check_eq("rst2_cnt", 32'(o_frame_count), 32'd0);
    req_data  = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      await_grant("all4", 2'(k), 8'hA0 + 8'(k));
      req_valid[k] = 1'b0;
    end
    wait_idle("all4");
    check_eq("all4_cnt", 32'(o_frame_count), 32'd4);

    // Pointer must be back at 0: requesters 1 and 3 are served 1 then 3
    req_data  = 32'h3300_1100;
    req_valid = 4'b1010;
    await_grant("ptr_probe_a", 2'd1, 8'h11);
    req_valid[1] = 1'b0;
    await_grant("ptr_probe_b", 2'd3, 8'h33);
    req_valid[3] = 1'b0;
    wait_idle("ptr_probe");
    check_eq("ptr_probe_cnt", 32'(o_frame_count), 32'd6);

    // Fairness: req0 held, req2 raised mid-frame
    req_data  = 32'h0032_0010;
    req_valid = 4'b0001;
    await_grant("fair_a", 2'd0, 8'h10);
    tick();
    tick();
    req_valid[2] = 1'b1;
    await_grant("fair_b", 2'd2, 8'h32);
    req_valid[2] = 1'b0;
    await_grant("fair_c", 2'd0, 8'h10);
    req_valid = 4'b0;
    wait_idle("fair");
    check_eq("fair_cnt", 32'(o_frame_count), 32'd9);

    // Held-level tx_done for 5 cycles
    done_len      = 5;
    req_data      = 32'h0000_5A00;
    req_valid     = 4'b0010;
    await_grant("held", 2'd1, 8'h5A);
    req_valid = 4'b0;
    wait_done("held");
    check_eq("held_start_drop", 32'(o_tx_start), 32'd0);
    check_eq("held_cnt_a", 32'(o_frame_count), 32'd10);
    repeat (4) tick();
    check_eq("held_in_release", 32'(o_busy), 32'd1);
    check_eq("held_cnt_b", 32'(o_frame_count), 32'd10);
    tick();
    check_eq("held_busy_low", 32'(o_busy), 32'd0);
    check_eq("held_cnt_c", 32'(o_frame_count), 32'd10);
    done_len = 1;

    // Reset mid-SEND
    done_mode = 2;
    req_data  = 32'hC300_0000;
    req_valid = 4'b1000;
    await_grant("midrst", 2'd3, 8'hC3);
    req_valid = 4'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_start", 32'(o_tx_start), 32'd0);
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    check_eq("midrst_cnt", 32'(o_frame_count), 32'd0);
    check_eq("midrst_id", 32'(o_grant_id), 32'd0);
    reset     = 1'b0;
    done_mode = 0;
    req_data  = 32'h0052_0050;
    req_valid = 4'b0101;
    await_grant("restart_a", 2'd0, 8'h50);
    req_valid[0] = 1'b0;
    await_grant("restart_b", 2'd2, 8'h52);
    req_valid[2] = 1'b0;
    wait_idle("restart");
    check_eq("restart_cnt", 32'(o_frame_count), 32'd2);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Watchdog abort after 50 SEND cycles, then next requester served
    done_mode = 2;
    req_data  = 32'h007C_6B00;
    req_valid = 4'b0010;
    await_grant("wdog", 2'd1, 8'h6B);
    req_valid = 4'b0100;
    repeat (49) tick();
    check_eq("wdog_err_early", 32'(o_timeout_err), 32'd0);
    check_eq("wdog_start_held", 32'(o_tx_start), 32'd1);
    tick();
    check_eq("wdog_err_pulse", 32'(o_timeout_err), 32'd1);
    check_eq("wdog_start_drop", 32'(o_tx_start), 32'd0);
    check_eq("wdog_cnt", 32'(o_frame_count), 32'd2);
    done_mode = 0;
    tick();
    check_eq("wdog_err_one_cycle", 32'(o_timeout_err), 32'd0);
    await_grant("wdog_next", 2'd2, 8'h7C);
    req_valid = 4'b0;
    wait_idle("wdog_next");
    check_eq("wdog_next_cnt", 32'(o_frame_count), 32'd3);
`else
    check_eq("no_wdog_err", 32'(o_timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares a single UART Transmitter among NUM_REQ byte producers using round-robin arbitration. Sits between the requesters and the Transmitter's tx_in/tx_start/tx_done interface. Sequences exactly one frame per grant. The Transmitter and BaudRateGenerator are unchanged; this block never sees baudTick.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, frame payload width; matches Transmitter tx_in
CNT_W, 16, width of frame_count
TIMEOUT_CYCLES, 200000, SEND-state watchdog limit in clock cycles (optional feature only)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request; held with req_data until own req_ready
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted
tx_in  out  DATA_W  byte to Transmitter; registered, stable for whole frame
tx_start  out  1  start level to Transmitter
tx_done  in  1  Transmitter frame-complete; may be pulse or held level
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
frame_count  out  CNT_W  completed frames, wraps 2^CNT_W-1 -> 0
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset, synchronous: state=IDLE; rr_ptr=0; all outputs 0, including tx_in, frame_count, grant_id. Reset asserted mid-frame drops tx_start at that edge. No frame counted. Partially sent bytes are not re-queued.
- FSM states: IDLE, SEND, RELEASE. All outputs are registered.
- IDLE behaviour:
  - If any req_valid, winner w = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At the next edge: tx_in<=req_data[w], grant_id<=w, req_ready[w]<=1 for exactly one cycle, tx_start<=1, state<=SEND.
  - Latency is one cycle from req_valid sampled to tx_start high.
  - If no req_valid, remain in IDLE with outputs held; tx_in keeps its last value.
- SEND behaviour:
  - tx_start is held 1.
  - On the first cycle tx_done==1: tx_start<=0, frame_count<=frame_count+1, state<=RELEASE.
  - req_valid changes are ignored in SEND.
- RELEASE behaviour:
  - tx_start is held 0.
  - Wait until tx_done==0, covering the held-level tx_done case.
  - Then rr_ptr<=(grant_id+1) mod NUM_REQ and state<=IDLE.
  - This guarantees a minimum 1-cycle tx_start low gap between frames, so back-to-back frames cost at least 2 idle cycles.
- Fairness:
  - A requester that keeps req_valid high receives at most one grant per full rotation while others are waiting.
  - A single active requester is regranted every frame.
- Simultaneous events:
  - tx_done==1 on the first SEND cycle is honoured; the frame completes.
  - req_valid deasserted before req_ready is a protocol violation; the bench must not do it, and behaviour is undefined.
- No arithmetic beyond mod-NUM_REQ pointer increment and wrapping frame_count.

Optional Feature:
UART_TX_SCHED_TIMEOUT_EN
- Defined:
  - 32-bit watchdog cleared on SEND entry and incremented each SEND cycle.
  - When it reaches TIMEOUT_CYCLES-1 without tx_done: tx_start<=0, timeout_err pulses 1 cycle, state<=RELEASE, frame_count unchanged.
  - tx_done on the same cycle as the timeout wins; normal completion, no error.
- Undefined: no counter; SEND waits indefinitely; timeout_err port remains, tied 0.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, SEND, RELEASE}.
  - UART_DATA_W=8 constant.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs req vector and rr_ptr; outputs winner index and any_req.
  - Instantiated once.
- Top holds FSM, registers and watchdog.

Test Plan:
- Single request, bench tx_done model (pulse 10 cycles after tx_start rises):
  - Stimulus: req_valid=4'b0001, req_data[7:0]=8'h75.
  - Response: req_ready=4'b0001 for 1 cycle; tx_in=8'h75 and tx_start=1 one cycle after req_valid; tx_start low the edge after tx_done; frame_count=1; busy low 2 cycles after tx_done.
- All four requesting, bytes 8'hA0..8'hA3:
  - Response: grant order 0,1,2,3 with tx_in A0,A1,A2,A3; frame_count=4; then rr_ptr=0.
- Round-robin fairness:
  - Stimulus: req0 held high continuously; req2 raised during req0's frame.
  - Response: next grant is 2, then 0.
- Held-level tx_done (high 5 cycles):
  - Response: stays in RELEASE until tx_done low; exactly one increment of frame_count.
- Reset mid-SEND:
  - Response: next edge tx_start=0, busy=0, frame_count=0, grant_id=0; a later request restarts at requester 0.
- With UART_TX_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, tx_done never asserted:
  - Response: timeout_err pulse 50 cycles after SEND entry; tx_start drops; frame_count unchanged; next requester served.
